// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Fetch-address sequencer with F/D/E PC tracking, branch
//               misprediction redirect, stall bubbling and saturating
//               resolved-branch / mispredict statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_f,
  input  logic [ADDR_WIDTH-1:0] predict_pc_f,
  input  logic                  branchfound_f,
  input  logic [ADDR_WIDTH-1:0] mispredict_pc_e,
  input  logic                  br_is_branch_e,
  input  logic                  br_taken_e,
  output logic [ADDR_WIDTH-1:0] pc_f,
  output logic [ADDR_WIDTH-1:0] pc_e,
  output logic                  branch_found_EXE,
  output logic                  branch_taken_EXE,
  output logic                  redirect_e,
  output logic                  valid_d,
  output logic                  valid_e,
  output logic [CNT_WIDTH-1:0]  br_cnt,
  output logic [CNT_WIDTH-1:0]  misp_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  logic [ADDR_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [ADDR_WIDTH-1:0] pc_d_q, pc_d_d;
  logic                  found_d_q, found_d_d;
  logic                  valid_d_q, valid_d_d;
  logic [ADDR_WIDTH-1:0] pc_e_q, pc_e_d;
  logic                  found_e_q, found_e_d;
  logic                  valid_e_q, valid_e_d;
  logic [CNT_WIDTH-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0]  misp_cnt_q, misp_cnt_d;

  logic brv;
  logic br_taken_v;
  logic redirect;

  // A valid E-stage branch and its resolved outcome. A predictor hit on a
  // non-branch counts as predicted-taken-but-not-taken, which the redirect
  // equation covers because br_taken_v is then 0.
  always_comb begin
    brv        = valid_e_q & br_is_branch_e;
    br_taken_v = brv & br_taken_e;
    redirect   = valid_e_q & ((found_e_q & ~br_taken_v) | (~found_e_q & br_taken_v));
  end

  // Next-state for the fetch pipeline: redirect beats stall, stall bubbles E.
  always_comb begin
    pc_f_d    = pc_f_q;
    pc_d_d    = pc_d_q;
    found_d_d = found_d_q;
    valid_d_d = valid_d_q;
    pc_e_d    = pc_e_q;
    found_e_d = found_e_q;
    valid_e_d = valid_e_q;
    if (redirect) begin
      pc_f_d    = mispredict_pc_e;
      valid_d_d = 1'b0;
      valid_e_d = 1'b0;
    end else if (stall_f) begin
      valid_e_d = 1'b0;
    end else begin
      pc_f_d    = predict_pc_f;
      pc_d_d    = pc_f_q;
      found_d_d = branchfound_f;
      valid_d_d = 1'b1;
      pc_e_d    = pc_d_q;
      found_e_d = found_d_q;
      valid_e_d = valid_d_q;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (brv && (br_cnt_q != c_cnt_max)) begin
      br_cnt_d = br_cnt_q + c_cnt_one;
    end
    if (redirect && (misp_cnt_q != c_cnt_max)) begin
      misp_cnt_d = misp_cnt_q + c_cnt_one;
    end
  end

  // State registers; reset overrides every other update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q     <= RESET_PC;
      pc_d_q     <= '0;
      found_d_q  <= 1'b0;
      valid_d_q  <= 1'b0;
      pc_e_q     <= '0;
      found_e_q  <= 1'b0;
      valid_e_q  <= 1'b0;
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else begin
      pc_f_q     <= pc_f_d;
      pc_d_q     <= pc_d_d;
      found_d_q  <= found_d_d;
      valid_d_q  <= valid_d_d;
      pc_e_q     <= pc_e_d;
      found_e_q  <= found_e_d;
      valid_e_q  <= valid_e_d;
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign pc_f             = pc_f_q;
  assign pc_e             = pc_e_q;
  assign valid_d          = valid_d_q;
  assign valid_e          = valid_e_q;
  assign redirect_e       = redirect;
  assign branch_found_EXE = valid_e_q & found_e_q;
  assign branch_taken_EXE = br_taken_v;
  assign br_cnt           = br_cnt_q;
  assign misp_cnt         = misp_cnt_q;

endmodule
`default_nettype wire
